// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - HI/LO op encodings, FSM states and op classification helper
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MFHI  = 3'd3,
    OP_MFLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BUSY  = 2'd3
  } hilo_state_e;

  // Codes outside the defined set behave exactly like NOP.
  function automatic logic is_hilo_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - EX-side op bus and multiplier handshake for hilo_unit
// Ports grouped here:
//   EX side    : op_valid, op, rs_val, rt_val, flush -> unit; rd_data, stall, busy <- unit
//   multiplier : mult_a, mult_b, mult_start, mult_is_signed <- unit; mult_s, mult_active -> unit
// slave is the hilo_unit view, master is the EX stage / multiplier wrapper view.
interface hilo_unit_if #(parameter int WIDTH = 32);

  logic               op_valid;
  logic [2:0]         op;
  logic [WIDTH-1:0]   rs_val;
  logic [WIDTH-1:0]   rt_val;
  logic               flush;
  logic [WIDTH-1:0]   rd_data;
  logic               stall;
  logic               busy;
  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic               mult_start;
  logic               mult_is_signed;
  logic [2*WIDTH-1:0] mult_s;
  logic               mult_active;

  modport slave (
    input  op_valid, op, rs_val, rt_val, flush, mult_s, mult_active,
    output rd_data, stall, busy, mult_a, mult_b, mult_start, mult_is_signed
  );

  modport master (
    output op_valid, op, rs_val, rt_val, flush, mult_s, mult_active,
    input  rd_data, stall, busy, mult_a, mult_b, mult_start, mult_is_signed
  );

endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register file and sequencer for the iterative multiplier
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; drops any running multiply
//   bus   : hilo_unit_if.slave - EX op bus (op_valid/op/rs_val/rt_val/flush,
//           rd_data/stall/busy) and multiplier handshake (mult_a/mult_b/
//           mult_start/mult_is_signed out, mult_s/mult_active in)
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  hilo_unit_if.slave bus
);

  hilo_state_e      state;
  hilo_state_e      state_next;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             discard;

  logic             op_live;
  logic             accept_mult;
  logic             mult_done;

  // An op only acts in IDLE and only if it is not being squashed.
  assign op_live     = bus.op_valid && !bus.flush && (state == ST_IDLE);
  assign accept_mult = op_live && ((bus.op == OP_MULT) || (bus.op == OP_MULTU));
  // mult_active is only meaningful once the multiplier has had a cycle to
  // raise it, which is why completion is only looked for in BUSY.
  assign mult_done   = (state == ST_BUSY) && !bus.mult_active;

  always_comb begin
    state_next     = state;
    bus.mult_start = 1'b0;
    case (state)
      ST_IDLE:  if (accept_mult) state_next = ST_ISSUE;
      ST_ISSUE: begin
        bus.mult_start = 1'b1;
        state_next     = ST_WAIT;
      end
      ST_WAIT:  state_next = ST_BUSY;
      ST_BUSY:  if (!bus.mult_active) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state != ST_IDLE);
    // Any real HI/LO op behind a running multiply waits; this orders
    // MTHI/MTLO and MFHI/MFLO against the pending product write.
    bus.stall   = bus.op_valid && is_hilo_op(bus.op) && (state != ST_IDLE) && !bus.flush;
    bus.rd_data = '0;
    if (bus.op_valid && (bus.op == OP_MFHI)) bus.rd_data = hi;
    else if (bus.op_valid && (bus.op == OP_MFLO)) bus.rd_data = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      hi                 <= '0;
      lo                 <= '0;
      discard            <= 1'b0;
      bus.mult_a         <= '0;
      bus.mult_b         <= '0;
      bus.mult_is_signed <= 1'b0;
    end else begin
      state <= state_next;

      if (accept_mult) begin
        bus.mult_a         <= bus.rs_val;
        bus.mult_b         <= bus.rt_val;
        bus.mult_is_signed <= (bus.op == OP_MULT);
      end

      if (op_live && (bus.op == OP_MTHI)) hi <= bus.rs_val;
      if (op_live && (bus.op == OP_MTLO)) lo <= bus.rs_val;

      // The multiplier cannot be aborted, so a flush only marks the result
      // as unwanted; a flush landing on the completion cycle also drops it.
      if (mult_done) begin
        if (!discard && !bus.flush) {hi, lo} <= bus.mult_s;
        discard <= 1'b0;
      end else if ((state != ST_IDLE) && bus.flush) begin
        discard <= 1'b1;
      end
    end
  end

endmodule
